// File: rtl/logic_arb_pkg.sv
// Shared types for the two-port logic unit arbiter: opcode and result-slot state enums
// plus the default operand width.
package logic_arb_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      OP_AND  = 2'b00,
      OP_OR   = 2'b01,
      OP_XOR  = 2'b10,
      OP_NAND = 2'b11
   } op_e;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

endpackage

// File: rtl/logic_unit.sv
// Combinational bitwise logic unit: y = a <op> b over the full width, no carries.
module logic_unit
   import logic_arb_pkg::*;
#(
   parameter int DATA_W = logic_arb_pkg::DATA_W
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  op_e               op,
   output logic [DATA_W-1:0] y
);

   always_comb begin
      // NOTE: y gets a default before the case so no path can leave it unassigned (no latch).
      y = '0;
      unique case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NAND: y = ~(a & b);
      endcase
   end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic_unit between two valid/ready requesters, with a
// registered, id-tagged result slot. Define ARB_STATS_EN to enable saturating grant counters.
module logic_unit_arbiter
   import logic_arb_pkg::*;
#(
   parameter int DATA_W = logic_arb_pkg::DATA_W,
   parameter int STAT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [DATA_W-1:0] req_a0,
   input  logic [DATA_W-1:0] req_a1,
   input  logic [DATA_W-1:0] req_b0,
   input  logic [DATA_W-1:0] req_b1,
   input  logic [1:0]        req_op0,
   input  logic [1:0]        req_op1,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_id,
   output logic [STAT_W-1:0] gnt_cnt0,
   output logic [STAT_W-1:0] gnt_cnt1
);

   state_e            state_q, state_d;
   logic              rr_last_q;
   logic              slot_free;
   logic              gnt_any;
   logic              gnt_id;
   logic [DATA_W-1:0] a_sel, b_sel, lu_y;
   op_e               op_sel;

   // A new result may be loaded when the slot is empty or is being drained this cycle.
   assign slot_free = (state_q == EMPTY) | rsp_ready;

   always_comb begin
      gnt_any = 1'b0;
      gnt_id  = 1'b0;
      if (slot_free) begin
         unique case (req_valid)
            2'b01:   begin gnt_any = 1'b1; gnt_id = 1'b0;       end
            2'b10:   begin gnt_any = 1'b1; gnt_id = 1'b1;       end
            2'b11:   begin gnt_any = 1'b1; gnt_id = ~rr_last_q; end
            default: begin gnt_any = 1'b0; gnt_id = 1'b0;       end
         endcase
      end
   end

   assign a_sel  = gnt_id ? req_a1 : req_a0;
   assign b_sel  = gnt_id ? req_b1 : req_b0;
   assign op_sel = op_e'(gnt_id ? req_op1 : req_op0);

   logic_unit #(.DATA_W(DATA_W)) u_logic_unit (
      .a  (a_sel),
      .b  (b_sel),
      .op (op_sel),
      .y  (lu_y)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= EMPTY;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         EMPTY: if (gnt_any)               state_d = FULL;
         FULL:  if (rsp_ready && !gnt_any) state_d = EMPTY;
      endcase
   end

   always_comb begin
      rsp_valid = (state_q == FULL);
      req_ready = 2'b00;
      if (gnt_any) req_ready = gnt_id ? 2'b10 : 2'b01;
   end

   // rr_last resets to 1 so port 0 wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_data  <= '0;
         rsp_id    <= 1'b0;
         rr_last_q <= 1'b1;
      end else if (gnt_any) begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         rsp_data  <= lu_y;
         rsp_id    <= gnt_id;
         rr_last_q <= gnt_id;
      end
   end

`ifdef ARB_STATS_EN
   logic [STAT_W-1:0] cnt0_q, cnt1_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else if (gnt_any) begin
         if (!gnt_id && (cnt0_q != '1)) cnt0_q <= cnt0_q + 1'b1;
         if ( gnt_id && (cnt1_q != '1)) cnt1_q <= cnt1_q + 1'b1;
      end
   end

   assign gnt_cnt0 = cnt0_q;
   assign gnt_cnt1 = cnt1_q;
`else
   assign gnt_cnt0 = '0;
   assign gnt_cnt1 = '0;
`endif

endmodule
